wash_sequencer: RTL

Program sequencer for the washing-machine panel. It owns the selected wash model, the active program stage, the run state and the remaining time. It drives `current_model`, `current_program` and `run_state` into the panel light/buzzer logic. It advances the wash, rinse and dry stages on 1 Hz ticks in response to the start and model-select buttons.

---
 rtl/wash_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wash_sequencer
// Description : Washing-machine program sequencer (model select, stage
//               advance on 1 Hz ticks, run/pause/done control).
// Revision    : 1.0 - initial release
// ============================================================================
module wash_sequencer #(
  parameter int WASH_T  = 6,
  parameter int RINSE_T = 4,
  parameter int DRY_T   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1HZ,
  input  logic       start,
  input  logic       model_choose,
  output logic [2:0] current_model,
  output logic [1:0] current_program,
  output logic [1:0] run_state,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] c_WASH6  = 6'(WASH_T);
  localparam logic [5:0] c_RINSE6 = 6'(RINSE_T);
  localparam logic [5:0] c_DRY6   = 6'(DRY_T);
  localparam logic [7:0] c_WASH8  = 8'(WASH_T);
  localparam logic [7:0] c_RINSE8 = 8'(RINSE_T);
  localparam logic [7:0] c_DRY8   = 8'(DRY_T);

  state_t     r_state, w_state;
  logic [2:0] r_model, w_model;
  logic [1:0] r_program, w_program;
  logic [7:0] r_remaining, w_remaining;
  logic [5:0] r_stage_cnt, w_stage_cnt;
  logic       start_q, model_q, tick_q;
  logic       w_start_ev, w_model_ev, w_tick_ev;
  logic [2:0] w_model_inc;

  // Stages of every model are contiguous, so only first and last are needed.
  function automatic logic [1:0] first_stage(input logic [2:0] m);
    case (m)
      3'd3, 3'd4: first_stage = 2'd1;
      3'd5:       first_stage = 2'd2;
      default:    first_stage = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_stage(input logic [2:0] m);
    case (m)
      3'd0, 3'd4, 3'd5: last_stage = 2'd2;
      3'd2, 3'd3:       last_stage = 2'd1;
      default:          last_stage = 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] stage_len(input logic [1:0] p);
    case (p)
      2'd0:    stage_len = c_WASH6;
      2'd1:    stage_len = c_RINSE6;
      default: stage_len = c_DRY6;
    endcase
  endfunction

  function automatic logic [7:0] model_total(input logic [2:0] m);
    case (m)
      3'd0:    model_total = c_WASH8 + c_RINSE8 + c_DRY8;
      3'd1:    model_total = c_WASH8;
      3'd2:    model_total = c_WASH8 + c_RINSE8;
      3'd3:    model_total = c_RINSE8;
      3'd4:    model_total = c_RINSE8 + c_DRY8;
      default: model_total = c_DRY8;
    endcase
  endfunction

  assign w_start_ev  = start & ~start_q;
  assign w_model_ev  = model_choose & ~model_q;
  assign w_tick_ev   = clk_1HZ & ~tick_q;
  // Values 5, 6 and 7 all step to model 0.
  assign w_model_inc = (r_model >= 3'd5) ? 3'd0 : r_model + 3'd1;

  always_comb begin
    w_state     = r_state;
    w_model     = r_model;
    w_program   = r_program;
    w_remaining = r_remaining;
    w_stage_cnt = r_stage_cnt;
    case (r_state)
      IDLE, DONE: begin
        if (w_start_ev) begin
          if (r_state == DONE) begin
            w_state     = IDLE;
            w_program   = first_stage(r_model);
            w_remaining = model_total(r_model);
            w_stage_cnt = stage_len(first_stage(r_model));
          end else begin
            w_state = RUN;
          end
        end else if (w_model_ev) begin
          w_state     = IDLE;
          w_model     = w_model_inc;
          w_program   = first_stage(w_model_inc);
          w_remaining = model_total(w_model_inc);
          w_stage_cnt = stage_len(first_stage(w_model_inc));
        end
      end
      RUN: begin
        if (w_tick_ev) begin
          w_remaining = (r_remaining != 8'd0) ? r_remaining - 8'd1 : 8'd0;
          if (r_stage_cnt <= 6'd1) begin
            if (r_program == last_stage(r_model)) begin
              w_state     = DONE;
              w_remaining = 8'd0;
              w_stage_cnt = 6'd0;
            end else begin
              w_program   = r_program + 2'd1;
              w_stage_cnt = stage_len(r_program + 2'd1);
            end
          end else begin
            w_stage_cnt = r_stage_cnt - 6'd1;
          end
        end
        // A tick that finishes the model takes precedence over pausing.
        if (w_start_ev && w_state != DONE) begin
          w_state = PAUSE;
        end
      end
      PAUSE: begin
        if (w_start_ev) begin
          w_state = RUN;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_model     <= 3'd0;
      r_program   <= 2'd0;
      r_remaining <= c_WASH8 + c_RINSE8 + c_DRY8;
      r_stage_cnt <= c_WASH6;
      start_q     <= 1'b1;
      model_q     <= 1'b1;
      tick_q      <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_model     <= w_model;
      r_program   <= w_program;
      r_remaining <= w_remaining;
      r_stage_cnt <= w_stage_cnt;
      start_q     <= start;
      model_q     <= model_choose;
      tick_q      <= clk_1HZ;
    end
  end

  assign current_model   = r_model;
  assign current_program = r_program;
  assign run_state       = r_state;
  assign remaining       = r_remaining;

endmodule
`default_nettype wire
